// File: rtl/count_sequencer.sv
// ---------------------------------------------------------------------------
// count_sequencer
//
// Controller for an external WIDTH-bit enable/clear counter, for example a
// T flip-flop ripple-enable counter. Start/Stop requests become a
// clear -> run -> (pause) -> done sequence. While running, the block issues
// one-cycle count enables at a prescaled rate until the live counter value
// equals Target. It then pulses Done and either returns to idle (one-shot)
// or clears and runs again (auto-restart).
//
// Parameters
//   WIDTH     width of the sequenced counter and of Target/Count
//   PRESCALE  clock cycles per count enable while running (>= 1)
//
// Ports
//   Clock      in   system clock, rising edge
//   Clear      in   asynchronous active-high reset
//   Start      in   start/resume request, acted on at its rising edge
//   Stop       in   pause/abort request, acted on at its rising edge
//   Mode       in   0 = one-shot, 1 = auto-restart
//   Target     in   terminal count value
//   Count      in   current value of the sequenced counter
//   Count_En   out  one-cycle count enable to the counter LSB stage
//   Count_Clr  out  one-cycle clear request to the counter
//   Done       out  one-cycle pulse after the target is reached
//   State      out  state encoding (IDLE=00 CLEARING=01 RUN=10 PAUSE=11)
//   Busy       out  high whenever State is not IDLE
// ---------------------------------------------------------------------------
module count_sequencer #(
   parameter int WIDTH    = 8,
   parameter int PRESCALE = 4
) (
   input  logic             Clock,
   input  logic             Clear,
   input  logic             Start,
   input  logic             Stop,
   input  logic             Mode,
   input  logic [WIDTH-1:0] Target,
   input  logic [WIDTH-1:0] Count,
   output logic             Count_En,
   output logic             Count_Clr,
   output logic             Done,
   output logic [1:0]       State,
   output logic             Busy
);

   // A prescaler of one still needs a one-bit register so the code stays
   // uniform; with PRESCALE=1 it simply sits at zero and wraps every cycle.
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

   typedef enum logic [1:0] {
      IDLE     = 2'b00,
      CLEARING = 2'b01,
      RUN      = 2'b10,
      PAUSE    = 2'b11
   } state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] presc_q, presc_d;
   logic          done_q, done_d;
   logic          start_hist_q;
   logic          stop_hist_q;

   logic          start_req;
   logic          stop_req;
   logic          target_hit;
   logic          presc_wrap;
   logic          count_en;

   // Requests are rising edges of the level inputs. The history bits come
   // out of reset high, so an input already held high when Clear is released
   // has to fall and rise again before it counts as a request.
   assign start_req  = Start & ~start_hist_q;
   assign stop_req   = Stop & ~stop_hist_q;

   // The compare uses the live Target so a mid-run change takes effect at
   // once; if Count has already passed it, counting wraps until equality.
   assign target_hit = (Count == Target);
   assign presc_wrap = (presc_q == PRESC_LAST);

   // Next-state logic. The target match in RUN outranks any request, and a
   // Stop request outranks a simultaneous Start request everywhere. Count_En
   // is only raised in RUN without a match, and Count_Clr only in CLEARING,
   // so the two can never be high together.
   always_comb begin
      state_d  = state_q;
      presc_d  = presc_q;
      done_d   = 1'b0;
      count_en = 1'b0;

      case (state_q)
         IDLE: begin
            if (start_req && !stop_req) begin
               state_d = CLEARING;
            end
         end

         CLEARING: begin
            state_d = RUN;
            presc_d = '0;
         end

         RUN: begin
            presc_d = presc_wrap ? '0 : presc_q + 1'b1;
            if (target_hit) begin
               done_d  = 1'b1;
               state_d = Mode ? CLEARING : IDLE;
            end else begin
               count_en = presc_wrap;
               if (stop_req) begin
                  state_d = PAUSE;
               end
            end
         end

         PAUSE: begin
            if (stop_req) begin
               state_d = IDLE;
            end else if (start_req) begin
               state_d = RUN;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, prescaler, Done pulse and the request history bits. Clear does
   // not touch the external counter; its value is cleared on the next Start
   // through the CLEARING state.
   always_ff @(posedge Clock or posedge Clear) begin
      if (Clear) begin
         state_q      <= IDLE;
         presc_q      <= '0;
         done_q       <= 1'b0;
         start_hist_q <= 1'b1;
         stop_hist_q  <= 1'b1;
      end else begin
         state_q      <= state_d;
         presc_q      <= presc_d;
         done_q       <= done_d;
         start_hist_q <= Start;
         stop_hist_q  <= Stop;
      end
   end

   // Count_Clr is a pure Moore decode of the CLEARING state, which lasts
   // exactly one cycle, so each clear is a single-cycle pulse.
   assign Count_En  = count_en;
   assign Count_Clr = (state_q == CLEARING);
   assign Done      = done_q;
   assign State     = state_q;
   assign Busy      = (state_q != IDLE);

endmodule

// File: tb/tb_count_sequencer.sv
// ---------------------------------------------------------------------------
// tb_count_sequencer
//
// Two sequencers share one clock and reset: unit 0 with PRESCALE=4 and
// unit 1 with PRESCALE=1. Each drives its own behavioural counter. The
// stimulus pushes the state changes it expects into a per-unit queue. The
// monitor pops an entry whenever that unit's State changes and compares the
// new state, Done, the dwell in the previous state, the enables issued in
// the previous state and the counter value.
// ---------------------------------------------------------------------------
module tb_count_sequencer;

   typedef struct packed {
      logic [1:0] state;
      logic       done;
      int         dwell;
      int         en;
      logic [7:0] count;
   } rec_t;

   logic       Clock;
   logic       Clear;
   logic       start_in  [2];
   logic       stop_in   [2];
   logic       mode_in   [2];
   logic [7:0] target_in [2];
   logic [7:0] cnt       [2];
   logic       cnt_load  [2];
   logic [7:0] load_val;
   logic       en_out    [2];
   logic       clr_out   [2];
   logic       done_out  [2];
   logic [1:0] state_out [2];
   logic       busy_out  [2];
   logic       mon_en;

   rec_t exp_q0 [$];
   rec_t exp_q1 [$];

   int vector_count;
   int miscompares;

   count_sequencer #(.WIDTH(8), .PRESCALE(4)) u_seq_p4 (
      .Clock    (Clock),
      .Clear    (Clear),
      .Start    (start_in[0]),
      .Stop     (stop_in[0]),
      .Mode     (mode_in[0]),
      .Target   (target_in[0]),
      .Count    (cnt[0]),
      .Count_En (en_out[0]),
      .Count_Clr(clr_out[0]),
      .Done     (done_out[0]),
      .State    (state_out[0]),
      .Busy     (busy_out[0])
   );

   count_sequencer #(.WIDTH(8), .PRESCALE(1)) u_seq_p1 (
      .Clock    (Clock),
      .Clear    (Clear),
      .Start    (start_in[1]),
      .Stop     (stop_in[1]),
      .Mode     (mode_in[1]),
      .Target   (target_in[1]),
      .Count    (cnt[1]),
      .Count_En (en_out[1]),
      .Count_Clr(clr_out[1]),
      .Done     (done_out[1]),
      .State    (state_out[1]),
      .Busy     (busy_out[1])
   );

   // Free-running clock, 10 time units per cycle.
   initial begin
      Clock = 1'b0;
      forever #5 Clock = ~Clock;
   end

   // Behavioural model of the sequenced counter: clear wins over enable,
   // and it is deliberately not reset by Clear.
   always @(posedge Clock) begin
      for (int i = 0; i < 2; i++) begin
         if (cnt_load[i]) begin
            cnt[i] <= load_val;
         end else if (clr_out[i]) begin
            cnt[i] <= 8'd0;
         end else if (en_out[i]) begin
            cnt[i] <= cnt[i] + 8'd1;
         end
      end
   end

   // Single comparison point: counts every vector and reports mismatches.
   task automatic checkOutput(input string name, input int got, input int want);
      vector_count++;
      if (got != want) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0d, required %0d", name, got, want);
      end
   endtask

   // Advance n rising edges, then step just past the edge to drive inputs.
   task automatic tick(input int n);
      repeat (n) @(posedge Clock);
      #1;
   endtask

   task automatic applyStimulus(input int u, input logic start, input logic stop);
      start_in[u] = start;
      stop_in[u]  = stop;
   endtask

   task automatic pulse_start(input int u);
      applyStimulus(u, 1'b1, 1'b0);
      tick(1);
      applyStimulus(u, 1'b0, 1'b0);
   endtask

   task automatic pulse_stop(input int u);
      applyStimulus(u, 1'b0, 1'b1);
      tick(1);
      applyStimulus(u, 1'b0, 1'b0);
   endtask

   task automatic pulse_both(input int u);
      applyStimulus(u, 1'b1, 1'b1);
      tick(1);
      applyStimulus(u, 1'b0, 1'b0);
   endtask

   // Queue one expected state change; dwell of -1 means "not checked".
   task automatic expect_rec(input int u, input logic [1:0] st, input logic dn,
                             input int dw, input int en, input logic [7:0] ct);
      rec_t r;
      r.state = st;
      r.done  = dn;
      r.dwell = dw;
      r.en    = en;
      r.count = ct;
      if (u == 0) exp_q0.push_back(r);
      else        exp_q1.push_back(r);
   endtask

   task automatic load_count(input int u, input logic [7:0] v);
      load_val    = v;
      cnt_load[u] = 1'b1;
      tick(1);
      cnt_load[u] = 1'b0;
   endtask

   // Monitor: samples on the falling edge, away from the active edge.
   initial begin : monitor
      logic [1:0] prev_state [2];
      int         dwell      [2];
      int         en_acc     [2];
      int         rec_idx    [2];
      bit         started;
      bit         changed;
      int         pending;
      int         bad;
      rec_t       r;
      started = 1'b0;
      for (int i = 0; i < 2; i++) rec_idx[i] = 0;
      forever begin
         @(negedge Clock);
         if (mon_en) begin
            if (!started) begin
               for (int i = 0; i < 2; i++) begin
                  checkOutput($sformatf("u%0d_reset_outputs", i),
                              int'({state_out[i], en_out[i], clr_out[i],
                                    done_out[i], busy_out[i]}), 0);
                  prev_state[i] = state_out[i];
                  dwell[i]      = 0;
                  en_acc[i]     = 0;
               end
               started = 1'b1;
            end else begin
               for (int i = 0; i < 2; i++) begin
                  changed = (state_out[i] != prev_state[i]);
                  bad = 0;
                  if (en_out[i] && clr_out[i])                 bad |= 1;
                  if (busy_out[i] != (state_out[i] != 2'b00))  bad |= 2;
                  if (clr_out[i] != (state_out[i] == 2'b01))   bad |= 4;
                  if (done_out[i] && !changed)                 bad |= 8;
                  checkOutput($sformatf("u%0d_invariants", i), bad, 0);
                  if (changed) begin
                     pending = (i == 0) ? exp_q0.size() : exp_q1.size();
                     checkOutput($sformatf("u%0d_expected_change_%0d", i, rec_idx[i]),
                                 (pending > 0) ? 1 : 0, 1);
                     if (pending > 0) begin
                        if (i == 0) r = exp_q0.pop_front();
                        else        r = exp_q1.pop_front();
                        checkOutput($sformatf("u%0d_rec%0d_state", i, rec_idx[i]),
                                    int'(state_out[i]), int'(r.state));
                        checkOutput($sformatf("u%0d_rec%0d_done", i, rec_idx[i]),
                                    int'(done_out[i]), int'(r.done));
                        if (r.dwell >= 0) begin
                           checkOutput($sformatf("u%0d_rec%0d_dwell", i, rec_idx[i]),
                                       dwell[i], r.dwell);
                        end
                        checkOutput($sformatf("u%0d_rec%0d_enables", i, rec_idx[i]),
                                    en_acc[i], r.en);
                        checkOutput($sformatf("u%0d_rec%0d_count", i, rec_idx[i]),
                                    int'(cnt[i]), int'(r.count));
                     end
                     rec_idx[i]++;
                     prev_state[i] = state_out[i];
                     dwell[i]      = 1;
                     en_acc[i]     = en_out[i] ? 1 : 0;
                  end else begin
                     dwell[i]++;
                     en_acc[i] += en_out[i] ? 1 : 0;
                  end
               end
            end
         end
      end
   end

   // Directed stimulus with hand-computed expected state changes.
   initial begin
      vector_count = 0;
      miscompares  = 0;
      mon_en       = 1'b0;
      load_val     = 8'd77;
      Clear        = 1'b0;
      for (int i = 0; i < 2; i++) begin
         start_in[i]  = 1'b0;
         stop_in[i]   = 1'b0;
         mode_in[i]   = 1'b0;
         target_in[i] = 8'd0;
         cnt_load[i]  = 1'b1;
      end
      #2 Clear = 1'b1;
      tick(3);
      Clear       = 1'b0;
      cnt_load[0] = 1'b0;
      cnt_load[1] = 1'b0;
      mon_en      = 1'b1;
      tick(2);

      // Unit 0, Target=3 one-shot: 13 RUN cycles with 3 enables, then Done.
      target_in[0] = 8'd3;
      mode_in[0]   = 1'b0;
      expect_rec(0, 2'b01, 1'b0, -1, 0, 8'd77);
      expect_rec(0, 2'b10, 1'b0,  1, 0, 8'd0);
      expect_rec(0, 2'b00, 1'b1, 13, 3, 8'd3);
      pulse_start(0);
      tick(20);

      // Unit 0 auto-restart: Done every 14 cycles; Mode dropped in 3rd run.
      mode_in[0] = 1'b1;
      expect_rec(0, 2'b01, 1'b0, -1, 0, 8'd3);
      expect_rec(0, 2'b10, 1'b0,  1, 0, 8'd0);
      expect_rec(0, 2'b01, 1'b1, 13, 3, 8'd3);
      expect_rec(0, 2'b10, 1'b0,  1, 0, 8'd0);
      expect_rec(0, 2'b01, 1'b1, 13, 3, 8'd3);
      expect_rec(0, 2'b10, 1'b0,  1, 0, 8'd0);
      expect_rec(0, 2'b00, 1'b1, 13, 3, 8'd3);
      pulse_start(0);
      tick(31);
      mode_in[0] = 1'b0;
      tick(20);

      // Unit 0 pause/resume: Stop in RUN cycle 6 holds prescaler at 2, Start
      // 10 cycles later gives an enable on the 2nd RUN cycle, then a pause
      // and a Stop in PAUSE abort to IDLE without Done.
      expect_rec(0, 2'b01, 1'b0, -1, 0, 8'd3);
      expect_rec(0, 2'b10, 1'b0,  1, 0, 8'd0);
      expect_rec(0, 2'b11, 1'b0,  6, 1, 8'd1);
      expect_rec(0, 2'b10, 1'b0, 10, 0, 8'd1);
      expect_rec(0, 2'b11, 1'b0,  3, 1, 8'd2);
      expect_rec(0, 2'b00, 1'b0,  4, 0, 8'd2);
      pulse_start(0);
      tick(6);
      pulse_stop(0);
      tick(9);
      pulse_start(0);
      tick(2);
      pulse_stop(0);
      tick(3);
      pulse_stop(0);
      tick(5);

      // Unit 0 simultaneous Start/Stop: ignored in IDLE, pauses in RUN.
      pulse_both(0);
      tick(3);
      expect_rec(0, 2'b01, 1'b0, -1, 0, 8'd2);
      expect_rec(0, 2'b10, 1'b0,  1, 0, 8'd0);
      expect_rec(0, 2'b11, 1'b0,  3, 0, 8'd0);
      expect_rec(0, 2'b00, 1'b0,  3, 0, 8'd0);
      pulse_start(0);
      tick(3);
      pulse_both(0);
      tick(2);
      pulse_stop(0);
      tick(3);

      // Unit 0 Target=0: Done two cycles after CLEARING, no enables.
      load_count(0, 8'd9);
      target_in[0] = 8'd0;
      expect_rec(0, 2'b01, 1'b0, -1, 0, 8'd9);
      expect_rec(0, 2'b10, 1'b0,  1, 0, 8'd0);
      expect_rec(0, 2'b00, 1'b1,  1, 0, 8'd0);
      pulse_start(0);
      tick(5);

      // Unit 0 Clear mid-RUN with Start held: async return to IDLE, and no
      // restart until Start falls and rises again.
      target_in[0] = 8'd3;
      expect_rec(0, 2'b01, 1'b0, -1, 0, 8'd0);
      expect_rec(0, 2'b10, 1'b0,  1, 0, 8'd0);
      expect_rec(0, 2'b00, 1'b0,  4, 1, 8'd1);
      applyStimulus(0, 1'b1, 1'b0);
      tick(6);
      #2 Clear = 1'b1;
      @(posedge Clock);
      @(posedge Clock);
      #1 Clear = 1'b0;
      tick(5);
      applyStimulus(0, 1'b0, 1'b0);
      tick(2);
      expect_rec(0, 2'b01, 1'b0, -1, 0, 8'd1);
      expect_rec(0, 2'b10, 1'b0,  1, 0, 8'd0);
      expect_rec(0, 2'b00, 1'b1, 13, 3, 8'd3);
      pulse_start(0);
      tick(20);

      // Unit 1, PRESCALE=1, Target=255: 255 enables then Done.
      target_in[1] = 8'd255;
      mode_in[1]   = 1'b0;
      expect_rec(1, 2'b01, 1'b0,  -1,   0, 8'd77);
      expect_rec(1, 2'b10, 1'b0,   1,   0, 8'd0);
      expect_rec(1, 2'b00, 1'b1, 256, 255, 8'd255);
      pulse_start(1);
      tick(265);

      // Unit 1 Target lowered to 2 at Count=5: wraps 255 -> 0 -> 2.
      target_in[1] = 8'd200;
      expect_rec(1, 2'b01, 1'b0,  -1,   0, 8'd255);
      expect_rec(1, 2'b10, 1'b0,   1,   0, 8'd0);
      expect_rec(1, 2'b00, 1'b1, 259, 258, 8'd2);
      pulse_start(1);
      tick(6);
      target_in[1] = 8'd2;
      tick(270);

      checkOutput("u0_leftover_expectations", exp_q0.size(), 0);
      checkOutput("u1_leftover_expectations", exp_q1.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vector_count, miscompares);
      $finish;
   end

endmodule
